// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage.
package alu_pkg;

    localparam int FLAG_BITS = 4;

    // Bit order matches flags_o: {N,Z,C,V}, N in bit 3.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [1:0] {
        RS_EMPTY,
        RS_ONE,
        RS_TWO
    } rs_state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational NZCV derivation from the ALU operands, the result and the overflow flag.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic             sel,
    input  logic [WIDTH-1:0] res,
    input  logic             v,
    output alu_flags_t       flags
);

    logic b_eff_msb;

    assign b_eff_msb = sel ? ~b_msb : b_msb;

    // Carry into the MSB is a^b^res there, so the carry-out follows from the MSB alone.
    assign flags.n = res[WIDTH-1];
    assign flags.z = (res == '0);
    assign flags.c = (a_msb & b_eff_msb) | ((a_msb | b_eff_msb) & ~res[WIDTH-1]);
    assign flags.v = v;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage with a 2-entry skid buffer and NZCV flag capture.
// Optional sticky overflow output enabled by defining ALU_STICKY_OVERFLOW_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     bus_a_i,
    input  logic [WIDTH-1:0]     bus_b_i,
    input  logic                 select_i,
    input  logic [WIDTH-1:0]     bus_i,
    input  logic                 flag_v_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WIDTH-1:0]     bus_o,
    output logic [FLAG_BITS-1:0] flags_o
`ifdef ALU_STICKY_OVERFLOW_EN
    ,
    input  logic                 clr_sticky_i,
    output logic                 sticky_v_o
`endif
);

    if (WIDTH < 2) begin : g_width_check
        $error("alu_result_stage: WIDTH must be at least 2");
    end

    rs_state_t        state, state_nxt;
    logic             accept, produce;
    logic             load_main_in, load_main_skid, load_skid;
    logic [WIDTH-1:0] main_bus, skid_bus;
    alu_flags_t       main_flags, skid_flags, in_flags;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .a_msb (bus_a_i[WIDTH-1]),
        .b_msb (bus_b_i[WIDTH-1]),
        .sel   (select_i),
        .res   (bus_i),
        .v     (flag_v_i),
        .flags (in_flags)
    );

    assign accept  = valid_i & ready_o;
    assign produce = valid_o & ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= RS_EMPTY;
            ready_o <= 1'b1;
        end else begin
            state   <= state_nxt;
            ready_o <= (state_nxt != RS_TWO);
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            RS_EMPTY: begin
                if (accept) begin
                    state_nxt    = RS_ONE;
                    load_main_in = 1'b1;
                end
            end
            RS_ONE: begin
                if (accept && produce) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_nxt = RS_TWO;
                    load_skid = 1'b1;
                end else if (produce) begin
                    state_nxt = RS_EMPTY;
                end
            end
            RS_TWO: begin
                // ready_o is low here, so valid_i cannot cause an accept.
                if (produce) begin
                    state_nxt      = RS_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = RS_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_bus   <= '0;
            main_flags <= '0;
            skid_bus   <= '0;
            skid_flags <= '0;
        end else begin
            if (load_main_in) begin
                main_bus   <= bus_i;
                main_flags <= in_flags;
            end else if (load_main_skid) begin
                main_bus   <= skid_bus;
                main_flags <= skid_flags;
            end
            if (load_skid) begin
                skid_bus   <= bus_i;
                skid_flags <= in_flags;
            end else if (load_main_skid) begin
                skid_bus   <= '0;
                skid_flags <= '0;
            end
        end
    end

    assign valid_o = (state != RS_EMPTY);
    assign bus_o   = main_bus;
    assign flags_o = main_flags;

    // Upstream contract: the result on bus_i is the wrapped sum a + b_eff + select.
    // Also the only consumer of the operand bits below the MSB.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> (bus_i == WIDTH'(bus_a_i + (select_i ? ~bus_b_i : bus_b_i) + WIDTH'(select_i))));

`ifdef ALU_STICKY_OVERFLOW_EN
    logic sticky;

    // A set in the same cycle as a clear takes priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sticky <= 1'b0;
        end else if (produce && main_flags.v) begin
            sticky <= 1'b1;
        end else if (clr_sticky_i) begin
            sticky <= 1'b0;
        end
    end

    assign sticky_v_o = sticky;
`endif

endmodule
